// File: rtl/rsc_encoder_if.sv
// Signal bundle between the interleaver output FIFO / block controller and rsc_encoder.
// The master side drives start, block select and FIFO data; the slave side is the encoder.
interface rsc_encoder_if #(
    parameter int USEDW_W = 9
);
    logic               i_start;
    logic               i_k_bit_in;
    logic [USEDW_W-1:0] i_fifo_usedw;
    logic               i_fifo_q;
    logic               o_fifo_rdreq;
    logic               o_out_valid;
    logic               o_sys_out;
    logic               o_par_out;
    logic               o_tail;
    logic               o_busy;
    logic               o_done;

    modport master (
        output i_start, i_k_bit_in, i_fifo_usedw, i_fifo_q,
        input  o_fifo_rdreq, o_out_valid, o_sys_out, o_par_out, o_tail, o_busy, o_done
    );

    modport slave (
        input  i_start, i_k_bit_in, i_fifo_usedw, i_fifo_q,
        output o_fifo_rdreq, o_out_valid, o_sys_out, o_par_out, o_tail, o_busy, o_done
    );
endinterface

// File: rtl/rsc_encoder.sv
// 8-state LTE RSC constituent encoder (g0 = 1+D^2+D^3, g1 = 1+D+D^3) fed from a non-show-ahead FIFO.
// Define RSC_TERMINATION_EN to append the 3 trellis-termination cycles after each block.
//   state | meaning
//   IDLE  | waiting for start
//   ENC   | reading FIFO and encoding K bits
//   TAIL  | 3 termination cycles (RSC_TERMINATION_EN only)
//   FIN   | block end, done issued next cycle
module rsc_encoder #(
    parameter int K_SMALL = 1056,
    parameter int K_LARGE = 6144,
    parameter int USEDW_W = 9
) (
    input  logic          clk,
    input  logic          reset,
    rsc_encoder_if.slave  bus
);
`ifdef RSC_TERMINATION_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ENC, ST_TAIL, ST_FIN} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ENC, ST_FIN} state_t;
`endif

    state_t      r_state;
    state_t      w_next;
    logic        r_k_large;
    logic [12:0] r_req_cnt;
    logic [12:0] r_enc_cnt;
    logic        r_s1, r_s2, r_s3;
    logic        r_rd_prev;
    logic        r_valid, r_sys, r_par, r_tail, r_busy, r_done;
    logic [12:0] w_k;
    logic        w_start_ok;
    logic        w_rdreq;
    logic        w_enc_fire;
    logic        w_enc_last;
    logic        w_fb, w_z;
`ifdef RSC_TERMINATION_EN
    logic [1:0]  r_tail_cnt;
    logic        w_u;
    assign w_u = r_s2 ^ r_s3;
`endif

    assign w_k        = r_k_large ? 13'(K_LARGE) : 13'(K_SMALL);
    // busy stays high through the done cycle, so a start seen there is dropped
    assign w_start_ok = bus.i_start && (r_state == ST_IDLE) && !r_busy;
    // usedw lags a read by one cycle; discount the read issued last cycle
    assign w_rdreq    = (r_state == ST_ENC) && (r_req_cnt < w_k) &&
                        (bus.i_fifo_usedw > {{(USEDW_W-1){1'b0}}, r_rd_prev});
    assign w_enc_fire = (r_state == ST_ENC) && r_rd_prev;
    assign w_enc_last = w_enc_fire && (r_enc_cnt == (w_k - 13'd1));
    assign w_fb       = bus.i_fifo_q ^ r_s2 ^ r_s3;
    assign w_z        = w_fb ^ r_s1 ^ r_s3;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_next = ST_ENC;
`ifdef RSC_TERMINATION_EN
            ST_ENC:  if (w_enc_last) w_next = ST_TAIL;
            ST_TAIL: if (r_tail_cnt == 2'd0) w_next = ST_FIN;
`else
            ST_ENC:  if (w_enc_last) w_next = ST_FIN;
`endif
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_k_large <= 1'b0;
            r_req_cnt <= '0;
            r_enc_cnt <= '0;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_rd_prev <= 1'b0;
            r_valid   <= 1'b0;
            r_sys     <= 1'b0;
            r_par     <= 1'b0;
            r_tail    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef RSC_TERMINATION_EN
            r_tail_cnt <= '0;
`endif
        end else begin
            r_state   <= w_next;
            r_rd_prev <= w_rdreq;
            r_valid   <= 1'b0;
            r_sys     <= 1'b0;
            r_par     <= 1'b0;
            r_tail    <= 1'b0;
            r_done    <= (r_state == ST_FIN);
            r_busy    <= (w_next != ST_IDLE) || (r_state == ST_FIN);
            if (w_rdreq) r_req_cnt <= r_req_cnt + 13'd1;
            if (w_enc_fire) begin
                r_sys     <= bus.i_fifo_q;
                r_par     <= w_z;
                r_valid   <= 1'b1;
                r_s1      <= w_fb;
                r_s2      <= r_s1;
                r_s3      <= r_s2;
                r_enc_cnt <= r_enc_cnt + 13'd1;
            end
`ifdef RSC_TERMINATION_EN
            // tail input u cancels the feedback, so the register flushes to 000
            if (r_state == ST_TAIL) begin
                r_sys      <= w_u;
                r_par      <= r_s1 ^ r_s3;
                r_tail     <= 1'b1;
                r_valid    <= 1'b1;
                r_s1       <= 1'b0;
                r_s2       <= r_s1;
                r_s3       <= r_s2;
                r_tail_cnt <= r_tail_cnt - 2'd1;
            end
            if (w_start_ok) r_tail_cnt <= 2'd2;
`endif
            if (w_start_ok) begin
                r_k_large <= bus.i_k_bit_in;
                r_req_cnt <= '0;
                r_enc_cnt <= '0;
                r_s1      <= 1'b0;
                r_s2      <= 1'b0;
                r_s3      <= 1'b0;
            end
        end
    end

    assign bus.o_fifo_rdreq = w_rdreq;
    assign bus.o_out_valid  = r_valid;
    assign bus.o_sys_out    = r_sys;
    assign bus.o_par_out    = r_par;
    assign bus.o_tail       = r_tail;
    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;
endmodule

// File: doc/rsc_encoder.md
# rsc_encoder

Constituent recursive systematic convolutional (RSC) encoder for the second turbo branch, directly downstream of the interleaver. It pulls interleaved bits c' one at a time from the interleaver output FIFO, encodes them with the 8-state LTE RSC (g0 = 1+D²+D³ feedback, g1 = 1+D+D³ feedforward) and emits systematic/parity bit pairs. With termination enabled it then appends the 3 trellis-termination cycles. Block size is selected per block by the same K select bit the interleaver uses.

## Interface
- K_SMALL, 1056: block length when k_bit_in = 0.
- K_LARGE, 6144: block length when k_bit_in = 1.
- USEDW_W, 9: width of the FIFO occupancy input.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low; clears all state when 0 at a clock edge.
- start  in  1  one-cycle pulse; begins a block. Ignored while busy = 1.
- k_bit_in  in  1  block size select; sampled only on an accepted start.
- fifo_usedw  in  USEDW_W  interleaver FIFO occupancy (updates one cycle after a read).
- fifo_q  in  1  FIFO data; valid the cycle after fifo_rdreq (normal, non-show-ahead).
- fifo_rdreq  out  1  FIFO read request.
- out_valid  out  1  sys_out/par_out valid this cycle.
- sys_out  out  1  systematic bit (tail: termination input bit).
- par_out  out  1  parity bit z.
- tail  out  1  qualifies out_valid cycles that are termination cycles.
- busy  out  1  block in progress.
- done  out  1  one-cycle pulse at block end.

## Operation
- Reset: all outputs 0, state IDLE, shift register {s1,s2,s3} = 000, counters 0.
- States: IDLE -> ENC on accepted start (latch K, clear counters and shift register); ENC -> TAIL when K bits have been encoded (or -> FIN if termination compiled out); TAIL -> FIN after 3 tail cycles; FIN -> IDLE unconditionally (done = 1 in FIN).
- Read control (ENC only): 13-bit req_cnt counts issued reads. fifo_rdreq = 1 when req_cnt < K and fifo_usedw > rd_prev, where rd_prev is fifo_rdreq of the previous cycle (guards the one-cycle usedw lag). Never more than K reads per block.
- Encode: on the cycle after each read, with c = fifo_q: fb = c^s2^s3; z = fb^s1^s3; register sys_out = c, par_out = z, out_valid = 1; shift s1<=fb, s2<=s1, s3<=s2. 13-bit enc_cnt increments; ENC ends when enc_cnt reaches K.
- Tail (3 cycles): u = s2^s3 (forces fb = 0); sys_out = u, par_out = s1^s3, tail = 1, out_valid = 1; shift with fb = 0. Register reaches 000 after the third cycle.
- FIFO empty mid-block: rdreq stays low; no shift, out_valid = 0; resumes without loss.
- start during busy: ignored, no effect on the running block. start in the FIN cycle: ignored.
- reset low mid-block: immediate abort to IDLE, all outputs 0 next cycle; upstream FIFO flush is not this block's job.

## Timing
- Read at cycle t -> fifo_q at t+1 -> sys_out/par_out registered, out_valid = 1 at t+2.
- Sustained rate 1 bit/cycle when FIFO never drains (fifo_usedw ≥ 2 throughout).
- Earliest first read: cycle after start. First out_valid: start + 3.
- Tail cycles immediately follow the last data output (no gap); done asserted the cycle after the last out_valid; busy is 1 from the cycle after start through the done cycle, 0 the following cycle.
- Uninterrupted K = 1056 block with termination: 1059 out_valid cycles, done at start + 1062.

## Configuration
- RSC_TERMINATION_EN defined: TAIL state present; 3 termination cycles with tail = 1 as above.
- Undefined: TAIL state removed, tail tied 0; ENC -> FIN directly; shift register simply cleared at the next start. done follows the last data output by one cycle (start + 1059 for K = 1056).

## Test plan
- K = 1056, all-zero FIFO data, FIFO pre-filled -> 1056 pairs sys = 0, par = 0, then 3 tail cycles with sys = 0, par = 0, done at start + 1062, exactly 1056 rdreq pulses.
- Impulse: first bit 1, rest 0, K = 1056 -> first 8 parity bits 1,1,1,1,0,0,1,0, then period-7 pattern 1,1,1,0,0,1,0 continuing from index 1; tail output matches bit-accurate model and state ends 000.
- K = 6144 random data vs. golden model -> 6144 + 3 outputs bit-exact; a following all-zero block yields all-zero parity (termination verified).
- FIFO drained mid-block (usedw = 0 for 20 cycles at bit 500) -> no rdreq, no out_valid gaps filled with garbage; output stream identical to uninterrupted run.
- Second start pulse at bit 300 -> ignored; block length and data unchanged; k_bit_in change at that pulse has no effect.
- reset = 0 at bit 700 -> next cycle busy = 0, out_valid = 0, fifo_rdreq = 0; fresh start afterwards encodes from state 000 correctly.
